btn_conditioner: RTL and testbench

- Parametrised front end for the N game push-buttons (right, left, shoot, reset) of the space_invaders top.
- Each raw asynchronous button is synchronised and debounced.
- Per channel it produces a clean level, one-cycle press and release pulses, and a fire strobe with optional auto-repeat. Auto-repeat is used for held movement buttons.
- Sits between the top-level button pins and the game control FSM. Replaces ad-hoc per-button edge logic.

---
 rtl/space_invaders_pkg.sv | 21 ++
 rtl/btn_channel.sv | 103 ++++++++++
 rtl/btn_conditioner.sv | 38 +++
 tb/tb_btn_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared constants for the space_invaders button front end.
// Cycle defaults derive from the 100 MHz system clock.
package space_invaders_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int unsigned HOLD_300MS    = (CLK_HZ / 1000) * 300;
    localparam int unsigned REPEAT_100MS  = CLK_HZ / 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop sync, debounce, edge pulses and
// an optional hold/repeat fire FSM.
module btn_channel
    import space_invaders_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_10MS,
    parameter int unsigned HOLD_DELAY_CYCLES    = HOLD_300MS,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_100MS,
    parameter bit          REPEAT_EN            = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic fire
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RW =
        $clog2(max2(HOLD_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_PERIOD_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rp_cnt;
    logic [1:0]    state;
    logic          flip;
    logic          rise;
    logic          fall;

    assign flip = (s2 != level) && (db_cnt == DB_LAST);
    assign rise = flip & s2;
    assign fall = flip & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
            rp_cnt <= '0;
            state  <= ST_IDLE;
            press  <= 1'b0;
            rel    <= 1'b0;
            fire   <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;

            // any sample matching the level restarts the debounce count
            if (s2 == level || flip) db_cnt <= '0;
            else                     db_cnt <= db_cnt + 1'b1;

            if (flip) level <= s2;

            press <= rise;
            rel   <= fall;
            fire  <= rise;

            if (fall) begin
                state  <= ST_IDLE;
                rp_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise && REPEAT_EN) begin
                            state  <= ST_HOLD;
                            rp_cnt <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (rp_cnt == HOLD_LAST) begin
                            fire   <= 1'b1;
                            state  <= ST_REPEAT;
                            rp_cnt <= '0;
                        end else begin
                            rp_cnt <= rp_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rp_cnt == RPT_LAST) begin
                            fire   <= 1'b1;
                            rp_cnt <= '0;
                        end else begin
                            rp_cnt <= rp_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        rp_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Game push-button front end: NUM_BTNS independent channels
// producing level, press/release pulses and fire strobes.
module btn_conditioner
    import space_invaders_pkg::*;
#(
    parameter int unsigned         NUM_BTNS             = 4,
    parameter int unsigned         DEBOUNCE_CYCLES      = DEBOUNCE_10MS,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK          = NUM_BTNS'(4'b0011),
    parameter int unsigned         HOLD_DELAY_CYCLES    = HOLD_300MS,
    parameter int unsigned         REPEAT_PERIOD_CYCLES = REPEAT_100MS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_fire
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .HOLD_DELAY_CYCLES    (HOLD_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .REPEAT_EN            (REPEAT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .fire  (btn_fire[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/hold/repeat
// constants so every cadence can be checked cycle by cycle.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_fire;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTNS             (4),
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_MASK          (4'b0011),
        .HOLD_DELAY_CYCLES    (10),
        .REPEAT_PERIOD_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_fire    (btn_fire)
    );

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        int         n;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] fir;
        int         fcnt;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // sample 30 cycles starting at the current one
    task automatic capture(input int drop_k, output logic [29:0] f0,
                           output logic [29:0] f1, output logic [29:0] r1);
        for (int k = 0; k < 30; k++) begin
            f0[k] = btn_fire[0];
            f1[k] = btn_fire[1];
            r1[k] = btn_release[1];
            if (k == drop_k) btn_raw[1] = 1'b0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [29:0] f0, f1, r1;
        int          acc;

        tbl[0]  = '{1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0, 0};
        tbl[1]  = '{1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0, 0};
        tbl[2]  = '{1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0, 0};
        tbl[3]  = '{1'b0, 4'hF, 5,  4'h0, 4'h0, 4'h0, 4'h0, 0};
        tbl[4]  = '{1'b0, 4'hF, 1,  4'hF, 4'hF, 4'h0, 4'hF, 4};
        tbl[5]  = '{1'b0, 4'hF, 1,  4'hF, 4'h0, 4'h0, 4'h0, 0};
        tbl[6]  = '{1'b1, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 0};
        tbl[7]  = '{1'b0, 4'h4, 5,  4'h0, 4'h0, 4'h0, 4'h0, 0};
        tbl[8]  = '{1'b0, 4'h4, 1,  4'h4, 4'h4, 4'h0, 4'h4, 1};
        tbl[9]  = '{1'b0, 4'h4, 49, 4'h4, 4'h0, 4'h0, 4'h0, 0};
        tbl[10] = '{1'b0, 4'h0, 5,  4'h4, 4'h0, 4'h0, 4'h0, 0};
        tbl[11] = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h4, 4'h0, 0};
        tbl[12] = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 0};

        rst     = 1'b1;
        btn_raw = 4'h0;

        for (int v = 0; v < 13; v++) begin
            rst     = tbl[v].rst;
            btn_raw = tbl[v].raw;
            acc     = 0;
            for (int c = 0; c < tbl[v].n; c++) begin
                step();
                acc += $countones(btn_fire);
            end
            chk($sformatf("v%0d.level", v), 32'(btn_level), 32'(tbl[v].lvl));
            chk($sformatf("v%0d.press", v), 32'(btn_press), 32'(tbl[v].prs));
            chk($sformatf("v%0d.release", v), 32'(btn_release),
                32'(tbl[v].rel));
            chk($sformatf("v%0d.fire", v), 32'(btn_fire), 32'(tbl[v].fir));
            chk($sformatf("v%0d.fire_cnt", v), 32'(acc), 32'(tbl[v].fcnt));
        end

        // bounce on ch0, then held: one press, then hold/repeat cadence
        rst = 1'b1; btn_raw = 4'h0; step();
        rst = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = (i % 2 == 0);
            for (int c = 0; c < 2; c++) begin
                step();
                acc += int'(btn_level[0]) + int'(btn_press[0])
                     + int'(btn_fire[0]);
            end
        end
        btn_raw[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            acc += int'(btn_level[0]) + int'(btn_press[0])
                 + int'(btn_fire[0]);
        end
        chk("bounce_quiet", 32'(acc), 32'd0);
        step();
        chk("bounce_press", 32'({btn_level[0], btn_press[0]}), 32'b11);
        capture(-1, f0, f1, r1);
        chk("repeat_ch0", 32'(f0), 32'h1249_2401);
        chk("repeat_cnt", 32'($countones(f0)), 32'd8);
        chk("repeat_ch1_idle", 32'(f1), 32'd0);

        // ch0+ch1 together, ch1 dropped during REPEAT
        rst = 1'b1; btn_raw = 4'h0; step();
        chk("rst_clear", 32'({btn_level, btn_press, btn_release, btn_fire}),
            32'd0);
        rst = 1'b0; btn_raw = 4'b0011;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            acc += $countones(btn_press);
        end
        chk("dual_early", 32'(acc), 32'd0);
        step();
        chk("dual_press", 32'({btn_press, btn_fire}), 32'h33);
        capture(14, f0, f1, r1);
        chk("dual_f0", 32'(f0), 32'h1249_2401);
        chk("dual_f1", 32'(f1), 32'h0009_2401);
        chk("dual_r1", 32'(r1), 32'h0010_0000);
        chk("dual_level", 32'(btn_level), 32'h1);

        // one-cycle reset mid-REPEAT with ch0 still held
        rst = 1'b1; step();
        chk("mid_rst", 32'({btn_level, btn_press, btn_release, btn_fire}),
            32'd0);
        rst = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            acc += int'(btn_press[0]) + int'(btn_level[0]);
        end
        chk("mid_rst_quiet", 32'(acc), 32'd0);
        step();
        chk("mid_rst_press", 32'({btn_press[0], btn_fire[0]}), 32'b11);
        capture(-1, f0, f1, r1);
        chk("mid_rst_cadence", 32'(f0), 32'h1249_2401);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
